// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter slice.
// Holds the arbiter FSM state encoding and the UART framing constants
// (8N1 at 9600 baud from a 50 MHz clock).
package uart_pkg;

  localparam int DATA_W       = 8;
  localparam int CLK_FREQ     = 50_000_000;
  localparam int BAUD         = 9600;
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;  // 5208 clocks per bit

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the requester handshake and transmitter control signals around
// the UART transmit arbiter.
//   req_valid/req_data : NUM_REQ byte requesters (byte i at [8*i+7:8*i])
//   req_ready          : one-hot pulse when a requester's byte is taken
//   tx_start/tx_data   : start pulse and byte towards the transmitter
//   tx_busy            : transmitter busy flag
//   grant_id, active, err_timeout : arbiter status
// Modports: slave = arbiter side, master = sources/transmitter side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import uart_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [DATA_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_busy;
  logic [2:0]                grant_id;
  logic                      active;
  logic                      err_timeout;

  modport slave (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_start, tx_data, grant_id, active, err_timeout
  );

  modport master (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_start, tx_data, grant_id, active, err_timeout
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req_i   : request vector
//   ptr_i   : index with highest priority this cycle (< NUM_REQ)
//   en_i    : qualifies the whole grant
//   gnt_o   : one-hot grant (zero when nothing is granted)
//   idx_o   : encoded index of the grant
//   valid_o : a grant was made
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [2:0]         ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [2:0]         idx_o,
  output logic               valid_o
);

  int   cand;
  logic found;

  // Walk the requesters starting at the pointer and wrapping; the first one
  // requesting wins. The inner loop keeps every bit-select constant.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (en_i && !found && req_i[i] && (cand == i)) begin
          found    = 1'b1;
          gnt_o[i] = 1'b1;
          idx_o    = 3'(i);
        end
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte requesters.
// Round-robin grant, latches the winning byte, pulses tx_start, follows the
// transmitter busy flag and enforces an idle gap before the next grant.
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : handshake/transmitter bundle (slave side)
// Parameters: NUM_REQ (2..8), GAP_CYCLES (idle cycles after a frame, 0 ok),
// START_TIMEOUT (cycles allowed for tx_busy to rise after tx_start, >= 1).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 8
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = 16'(START_TIMEOUT - 1);

  arb_state_e         state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [2:0]         grant_q, grant_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic               arb_en;
  logic               arb_valid;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [2:0]         arb_idx;
  logic [DATA_W-1:0]  sel_byte;

  // Grants are only possible in IDLE with the transmitter free; this also
  // covers the wait for tx_busy to drop after a reset mid-frame.
  assign arb_en = (state_q == IDLE) && !bus.tx_busy;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i   (bus.req_valid),
    .ptr_i   (ptr_q),
    .en_i    (arb_en),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Pick the granted requester's byte out of the flat data bus.
  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) sel_byte = bus.req_data[DATA_W*i +: DATA_W];
    end
  end

  // Next-state logic. One counter serves both the start timeout and the gap
  // because the two phases never overlap; it is cleared on entry to each.
  // A timeout is registered so the pulse lands in the first cycle after the
  // START_TIMEOUT allowed WAIT_BUSY cycles.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          data_d  = sel_byte;
          grant_d = arb_idx;
          ptr_d   = (arb_idx == 3'(NUM_REQ - 1)) ? 3'd0 : arb_idx + 3'd1;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          cnt_d   = '0;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) state_d = IDLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, latched byte and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready   = arb_gnt;
  assign bus.tx_start    = (state_q == START);
  assign bus.tx_data     = data_q;
  assign bus.grant_id    = grant_q;
  assign bus.active      = (state_q != IDLE);
  assign bus.err_timeout = err_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (8N1, 50 MHz clk, 9600 baud) between NUM_REQ byte requesters.
- Round-robin grant; latches the winner's byte and drives the transmitter's start/data inputs.
- Tracks the transmitter's busy flag and enforces an inter-frame gap before the next grant.
- Sits between the switch/command sources and the transmitter inside top.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 16, idle clk cycles between frame end (tx_busy fall) and next grant; 0 allowed.
- START_TIMEOUT, 8, cycles allowed for tx_busy to rise after tx_start.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester byte valid; must hold with stable data until its req_ready.
- req_data  input  8*NUM_REQ  byte i at [8*i+7:8*i].
- req_ready  output  NUM_REQ  one-cycle pulse per accepted byte; one-hot or zero.
- tx_start  output  1  one-cycle start pulse to the transmitter.
- tx_data  output  8  byte to transmit; stable from tx_start until frame end.
- tx_busy  input  1  transmitter busy (high from start bit through stop bit).
- grant_id  output  3  index of the current or last granted requester.
- active  output  1  high in any state except IDLE.
- err_timeout  output  1  one-cycle pulse when tx_busy fails to rise within START_TIMEOUT.

Behaviour:
- Reset (reset=0, async): state=IDLE, rr pointer=0, req_ready=0, tx_start=0, tx_data=0, grant_id=0, active=0, err_timeout=0, counters=0.
- IDLE: if tx_busy=0 and any req_valid, pick the first valid index at or after the pointer (wrapping modulo NUM_REQ). In the same cycle: req_ready[w]=1, latch tx_data=req_data[w], grant_id=w, pointer=(w+1) mod NUM_REQ. Next state: START. If tx_busy=1 in IDLE, no grant.
- START: tx_start=1 for exactly this cycle. Next state: WAIT_BUSY. Latency from req_valid sampled to tx_start is 1 cycle.
- WAIT_BUSY: count cycles.
  - On tx_busy=1: go to WAIT_DONE.
  - If the count reaches START_TIMEOUT with tx_busy still 0: err_timeout=1 for one cycle, go to GAP; the byte is dropped and not retried.
- WAIT_DONE: hold tx_data. On tx_busy falling to 0, go to GAP (or IDLE if GAP_CYCLES=0).
- GAP: count GAP_CYCLES cycles, then go to IDLE. Requests are ignored during GAP.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,NUM_REQ-1,0. A requester that drops valid loses no position; the pointer advances only past granted indices.
- Simultaneous events: a new req_valid in the same cycle tx_busy falls is not granted until GAP completes. A requester deasserting valid before ready violates protocol; behaviour is undefined but the FSM must not hang.
- Reset mid-frame returns to IDLE immediately with tx_start=0. Any in-progress transmitter frame is the transmitter's responsibility; after reset release, the arbiter waits for tx_busy=0 before granting.
- grant_id width is fixed at 3; the upper bits are 0 when NUM_REQ<8.

Decomposition:
- Shared package uart_pkg: the state enum (IDLE, START, WAIT_BUSY, WAIT_DONE, GAP), DATA_W=8, CLK_FREQ=50_000_000, BAUD=9600, CLKS_PER_BIT=5208.
- One sub-module, rr_arbiter:
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant and encoded index.
  - Combinational, parameterised by NUM_REQ.
- The FSM, counters and data latch stay in uart_tx_arbiter.

Test Plan:
- Reset then single request: req_valid=0001, req_data[7:0]=8'h31 → req_ready=0001 for 1 cycle, tx_start 1 cycle later, tx_data=8'h31, tx line shows start bit + 8'h31 LSB-first + stop bit, 52080 cycles per frame.
- All four requesters valid with bytes 8'hA0..8'hA3 → tx order A0,A1,A2,A3,A0; each frame separated by ≥16 idle cycles after tx_busy falls.
- Requester 2 only, pointer at 3 → wrap search grants index 2; pointer becomes 3.
- Transmitter model holds tx_busy=0 after tx_start → err_timeout pulses exactly 8 cycles after WAIT_BUSY entry; FSM returns to IDLE after the gap; next request is served.
- Assert reset (0) mid-frame during WAIT_DONE → all outputs at reset values immediately; no grant until tx_busy=0 after release.
- tx_busy held high before any request → no req_ready and no tx_start until tx_busy=0.
